// File: rtl/sram_mem_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : sram_mem_controller_if                                          |
// | Brief     : MA-stage request/response bus between the pipeline (master)     |
// |             and the SRAM memory controller (slave).                         |
// | Revision  : 1.0  initial release                                            |
// +-----------------------------------------------------------------------------+
interface sram_mem_controller_if;
  logic        mem_r_en;    // read request
  logic        mem_w_en;    // write request
  logic [31:0] address;     // byte address, word aligned
  logic [31:0] data;        // write data
  logic [31:0] mem_result;  // read data, valid while ready=1 in DONE
  logic        ready;       // 0 = busy, pipeline freezes

  modport master (
    output mem_r_en, mem_w_en, address, data,
    input  mem_result, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, data,
    output mem_result, ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : sram_mem_controller                                             |
// | Brief     : Serves 32-bit word reads/writes from the MA stage out of a      |
// |             16-bit external SRAM as two half-word phases (LO then HI),      |
// |             holding ready low while the access is in flight.                |
// | Revision  : 1.0  initial release                                            |
// +-----------------------------------------------------------------------------+
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,          // synchronous, active-low
  sram_mem_controller_if.slave    mem_bus,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [15:0]             sram_dq_out,
  output logic                    sram_dq_oe,
  input  wire logic [15:0]        sram_dq_in,
  output logic                    sram_we_n,
  output logic                    sram_oe_n
);

  // Phase counter runs 0 .. WAIT_CYCLES-1 inside each half-word phase.
  localparam int unsigned c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q,   state_d;
  logic [c_CNT_W-1:0]   cnt_q,     cnt_d;
  logic                 is_wr_q,   is_wr_d;
  logic [SRAM_AW-2:0]   idx_q,     idx_d;
  logic [31:0]          wdata_q,   wdata_d;
  logic [15:0]          rd_lo_q,   rd_lo_d;
  logic [31:0]          result_q,  result_d;
  logic [SRAM_AW-1:0]   addr_q,    addr_d;
  logic [15:0]          dq_out_q,  dq_out_d;
  logic                 dq_oe_q,   dq_oe_d;
  logic                 we_n_q,    we_n_d;
  logic                 oe_n_q,    oe_n_d;

  logic                 w_req;
  logic                 w_last;
  logic [31:0]          w_off;
  logic [SRAM_AW-2:0]   w_idx;
  logic                 w_unused_off;

  // Word index relative to the data-space base; wraps modulo the SRAM size.
  assign w_off        = mem_bus.address - 32'(BASE_ADDR);
  assign w_idx        = w_off[SRAM_AW:2];
  assign w_unused_off = &{1'b0, w_off[31:SRAM_AW+1], w_off[1:0]};

  assign w_req  = mem_bus.mem_r_en | mem_bus.mem_w_en;
  assign w_last = (cnt_q == c_LAST);

  // Ready is combinational so a new request freezes the pipeline in its own cycle.
  assign mem_bus.ready      = (state_q == S_DONE) || ((state_q == S_IDLE) && !w_req);
  assign mem_bus.mem_result = result_q;

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

  // Next-state, datapath and look-ahead SRAM pin values (pins are registered, glitch-free).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rd_lo_d  = rd_lo_q;
    result_d = result_q;
    addr_d   = addr_q;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          state_d = S_LO;
          cnt_d   = '0;
          is_wr_d = mem_bus.mem_w_en;      // write wins when both are asserted
          idx_d   = w_idx;
          wdata_d = mem_bus.data;
          addr_d  = {w_idx, 1'b0};
        end
      end
      S_LO: begin
        if (w_last) begin
          state_d = S_HI;
          cnt_d   = '0;
          addr_d  = {idx_q, 1'b1};
          if (!is_wr_q) begin
            rd_lo_d = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      S_HI: begin
        if (w_last) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = is_wr_q ? 32'h0 : {sram_dq_in, rd_lo_q};
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      S_DONE: begin
        // Never re-serve from DONE; a request still held is picked up in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin values for the cycle being entered. The write strobe is released on
    // the last phase cycle so data stays driven one cycle past the strobe.
    dq_out_d = 16'h0;
    dq_oe_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    if ((state_d == S_LO) || (state_d == S_HI)) begin
      if (is_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == S_LO) ? wdata_d[15:0] : wdata_d[31:16];
        we_n_d   = (cnt_d == c_LAST);
      end else begin
        oe_n_d   = 1'b0;
      end
    end
  end

  // State, datapath and SRAM pin registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      rd_lo_q  <= 16'h0;
      result_q <= 32'h0;
      addr_q   <= '0;
      dq_out_q <= 16'h0;
      dq_oe_q  <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rd_lo_q  <= rd_lo_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : tb_sram_mem_controller                                          |
// | Brief     : Self-checking bench: SRAM array model, word-level reference     |
// |             memory, vector table, corner sequences and random accesses.     |
// | Revision  : 1.0  initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_sram_mem_controller;

  localparam int          W    = 4;
  localparam int unsigned BASE = 1024;
  localparam int          AW   = 18;
  localparam int          BUSY = 2 * W + 1;          // ready-low cycles per access
  localparam int unsigned KEY_MASK = (1 << (AW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_mem_controller_if mem_bus();

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;

  sram_mem_controller #(
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_bus     (mem_bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  // External SRAM: asynchronous read while oe_n low, write while we_n low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

  int we_low_cnt = 0;
  int oe_low_cnt = 0;
  int oe_drv_cnt = 0;
  int viol_cnt   = 0;

  always @(negedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] = sram_dq_out;
    if (!sram_we_n) we_low_cnt++;
    if (!sram_oe_n) oe_low_cnt++;
    if (sram_dq_oe) oe_drv_cnt++;
    if (!sram_we_n && (!sram_dq_oe || !sram_oe_n)) viol_cnt++;
    if (sram_dq_oe && !sram_oe_n) viol_cnt++;
  end

  // Word-level reference memory keyed by wrapped word index.
  logic [31:0] ref_words [int];

  function automatic int key_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'(BASE)) >> 2;
    return int'(off & 32'(KEY_MASK));
  endfunction

  function automatic logic [31:0] ref_read(input int k);
    if (ref_words.exists(k)) return ref_words[k];
    return 32'h0;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request/response handshake; returns read data at DONE and ready-low cycles.
  task automatic do_access(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] res,
                           output int busy);
    @(negedge clk);
    mem_bus.mem_r_en = op[0];
    mem_bus.mem_w_en = op[1];
    mem_bus.address  = addr;
    mem_bus.data     = wd;
    we_low_cnt = 0;
    oe_low_cnt = 0;
    oe_drv_cnt = 0;
    busy = 0;
    #1;
    while (mem_bus.ready !== 1'b1 && busy < 50) begin
      busy++;
      @(negedge clk);
      #1;
    end
    res = mem_bus.mem_result;
    mem_bus.mem_r_en = 1'b0;
    mem_bus.mem_w_en = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;       // bit0 read, bit1 write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_res;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] res;
  int          busy;
  logic        ready_log [20];
  int          ones;

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    mem_bus.mem_r_en = 1'b0;
    mem_bus.mem_w_en = 1'b0;
    mem_bus.address  = 32'h0;
    mem_bus.data     = 32'h0;

    // ---------------- reset state ----------------
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready",      32'(mem_bus.ready), 32'd1);
    chk("rst_mem_result", mem_bus.mem_result, 32'h0);
    chk("rst_sram_addr",  32'(sram_addr),     32'h0);
    chk("rst_dq_out",     32'(sram_dq_out),   32'h0);
    chk("rst_dq_oe",      32'(sram_dq_oe),    32'd0);
    chk("rst_we_n",       32'(sram_we_n),     32'd1);
    chk("rst_oe_n",       32'(sram_oe_n),     32'd1);
    rst = 1'b1;

    // ---------------- vector table ----------------
    vecs[0]  = '{2'b10, 32'd1024,   32'hDEADBEEF, 32'h0};
    vecs[1]  = '{2'b01, 32'd1024,   32'h0,        32'hDEADBEEF};
    vecs[2]  = '{2'b10, 32'd1028,   32'h12345678, 32'h0};
    vecs[3]  = '{2'b01, 32'd1024,   32'h0,        32'hDEADBEEF};
    vecs[4]  = '{2'b01, 32'd1028,   32'h0,        32'h12345678};
    vecs[5]  = '{2'b11, 32'd1032,   32'hA5A5A5A5, 32'h0};
    vecs[6]  = '{2'b01, 32'd1032,   32'h0,        32'hA5A5A5A5};
    vecs[7]  = '{2'b10, 32'd0,      32'hCAFEF00D, 32'h0};
    vecs[8]  = '{2'b01, 32'd0,      32'h0,        32'hCAFEF00D};
    vecs[9]  = '{2'b01, 32'd525312, 32'h0,        32'hDEADBEEF};  // aliases word 0
    vecs[10] = '{2'b01, 32'd1036,   32'h0,        32'h0};         // never written

    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, res, busy);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(BUSY));
      chk($sformatf("vec%0d_we_low", i), 32'(we_low_cnt), vecs[i].op[1] ? 32'(2*(W-1)) : 32'd0);
      chk($sformatf("vec%0d_oe_low", i), 32'(oe_low_cnt), vecs[i].op[1] ? 32'd0 : 32'(2*W));
      if (vecs[i].op[1]) begin
        chk($sformatf("vec%0d_dq_drive", i), 32'(oe_drv_cnt), 32'(2*W));
        ref_words[key_of(vecs[i].addr)] = vecs[i].wdata;
      end
    end

    chk("sram_w0_lo",   32'(sram_mem[0]),        32'h0000BEEF);
    chk("sram_w0_hi",   32'(sram_mem[1]),        32'h0000DEAD);
    chk("sram_w1_lo",   32'(sram_mem[2]),        32'h00005678);
    chk("sram_w1_hi",   32'(sram_mem[3]),        32'h00001234);
    chk("sram_wrap_lo", 32'(sram_mem[18'h3FE00]), 32'h0000F00D);

    // ---------------- read held high through DONE ----------------
    @(negedge clk);
    mem_bus.mem_r_en = 1'b1;
    mem_bus.address  = 32'd1024;
    oe_low_cnt = 0;
    ones = 0;
    res = 32'h0;
    for (int c = 0; c < 20; c++) begin
      #1;
      ready_log[c] = mem_bus.ready;
      if (ready_log[c]) ones++;
      if (c == 19) res = mem_bus.mem_result;
      if (c < 19) @(negedge clk);
    end
    mem_bus.mem_r_en = 1'b0;
    chk("hold_ready_done1", 32'(ready_log[9]),  32'd1);
    chk("hold_ready_reissue", 32'(ready_log[10]), 32'd0);
    chk("hold_ready_done2", 32'(ready_log[19]), 32'd1);
    chk("hold_ready_count", 32'(ones),          32'd2);
    chk("hold_result",      res,                32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("hold_idle_ready",  32'(mem_bus.ready), 32'd1);
    @(negedge clk);
    #1;
    chk("hold_oe_low_total", 32'(oe_low_cnt),   32'(4*W));

    // ---------------- reset during HI of a write ----------------
    @(negedge clk);
    mem_bus.mem_w_en = 1'b1;
    mem_bus.address  = 32'd1040;
    mem_bus.data     = 32'h11112222;
    repeat (W + 2) @(negedge clk);
    #1;
    chk("abort_we_in_hi",   32'(sram_we_n),       32'd0);
    chk("abort_addr_hi",    32'(sram_addr),       32'd9);
    chk("abort_result_pre", mem_bus.mem_result,   32'hDEADBEEF);
    rst = 1'b0;
    mem_bus.mem_w_en = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_we_n",       32'(sram_we_n),       32'd1);
    chk("abort_dq_oe",      32'(sram_dq_oe),      32'd0);
    chk("abort_result",     mem_bus.mem_result,   32'h0);
    chk("abort_ready",      32'(mem_bus.ready),   32'd1);
    chk("abort_sram_addr",  32'(sram_addr),       32'h0);
    rst = 1'b1;

    // ---------------- randomized accesses vs reference ----------------
    for (int n = 0; n < 30; n++) begin
      int          idx;
      int          alias_n;
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] expv;
      idx     = int'($urandom_range(16, 79));
      alias_n = int'($urandom_range(0, 3));
      op      = 2'($urandom_range(1, 3));
      wd      = $urandom;
      addr    = 32'(BASE) + 32'd4 * (32'(idx) + 32'(alias_n) * 32'd131072);
      expv    = op[1] ? 32'h0 : ref_read(key_of(addr));
      do_access(op, addr, wd, res, busy);
      chk($sformatf("rnd%0d_result", n), res, expv);
      chk($sformatf("rnd%0d_busy", n), 32'(busy), 32'(BUSY));
      if (op[1]) ref_words[key_of(addr)] = wd;
    end

    chk("pin_protocol_violations", 32'(viol_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
